// File: rtl/add_result_queue_if.sv
// Handshake bundle between the ripple-carry adder, the result queue and its consumer.
// master = producer/consumer environment, slave = the queue itself.
interface add_result_queue_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_ovf;
  logic             out_neg;
  logic             out_zero;
  logic             out_carry;

  modport master (
    output in_valid, op_a, op_b, sum, cout, out_ready,
    input  in_ready, out_valid, out_sum, out_ovf, out_neg, out_zero, out_carry
  );

  modport slave (
    input  in_valid, op_a, op_b, sum, cout, out_ready,
    output in_ready, out_valid, out_sum, out_ovf, out_neg, out_zero, out_carry
  );
endinterface

// File: rtl/add_result_queue.sv
// Result queue behind the 32-bit adder: derives signed flags at push, optionally
// saturates on signed overflow, buffers entries in a small FIFO and keeps overflow stats.
module add_result_queue #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 4,
  parameter bit SATURATE = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  add_result_queue_if.slave  bus,
  input  logic               clr_stats,
  output logic [15:0]        ovf_count,
  output logic               ovf_sticky
);

  localparam int            AW   = $clog2(DEPTH);
  localparam logic [AW:0]   FULL = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST = AW'(DEPTH-1);

  logic [WIDTH-1:0] mem_sum [DEPTH];
  logic [DEPTH-1:0] mem_ovf;
  logic [DEPTH-1:0] mem_neg;
  logic [DEPTH-1:0] mem_zero;
  logic [DEPTH-1:0] mem_carry;

  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;

  logic             push;
  logic             pop;
  logic             in_ovf;
  logic             in_neg;
  logic             in_zero;
  logic [WIDTH-1:0] in_sum_st;

  // Ready/valid come only from the count register: no out_ready -> in_ready path.
  assign bus.in_ready  = (count < FULL);
  assign bus.out_valid = (count != '0);
  assign push          = bus.in_valid && bus.in_ready;
  assign pop           = bus.out_valid && bus.out_ready;

  always_comb begin
    in_ovf    = (bus.op_a[WIDTH-1] == bus.op_b[WIDTH-1]) &&
                (bus.sum[WIDTH-1] != bus.op_a[WIDTH-1]);
    in_sum_st = bus.sum;
    if (SATURATE && in_ovf)
      in_sum_st = bus.op_a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                    : {1'b0, {(WIDTH-1){1'b1}}};
    in_neg    = in_sum_st[WIDTH-1];
    in_zero   = (in_sum_st == '0);
  end

  assign bus.out_sum   = mem_sum[rd_ptr];
  assign bus.out_ovf   = mem_ovf[rd_ptr];
  assign bus.out_neg   = mem_neg[rd_ptr];
  assign bus.out_zero  = mem_zero[rd_ptr];
  assign bus.out_carry = mem_carry[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++)
        mem_sum[i] <= '0;
      mem_ovf   <= '0;
      mem_neg   <= '0;
      mem_zero  <= '0;
      mem_carry <= '0;
    end else if (push) begin
      mem_sum[wr_ptr]   <= in_sum_st;
      mem_ovf[wr_ptr]   <= in_ovf;
      mem_neg[wr_ptr]   <= in_neg;
      mem_zero[wr_ptr]  <= in_zero;
      mem_carry[wr_ptr] <= bus.cout;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Clear wins over a same-cycle overflow push; the counter holds at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_count  <= '0;
      ovf_sticky <= 1'b0;
    end else if (clr_stats) begin
      ovf_count  <= '0;
      ovf_sticky <= 1'b0;
    end else if (push && in_ovf) begin
      ovf_sticky <= 1'b1;
      if (ovf_count != '1)
        ovf_count <= ovf_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_add_result_queue.sv
// Directed bench for add_result_queue: one wrapping instance and one saturating
// instance share the same stimulus.
module tb_add_result_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [31:0] sum;
  logic        cout;
  logic        out_ready;
  logic        clr_stats;
  logic [15:0] ovf_count0, ovf_count1;
  logic        ovf_sticky0, ovf_sticky1;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  add_result_queue_if #(.WIDTH(32)) i0 ();
  add_result_queue_if #(.WIDTH(32)) i1 ();

  assign i0.in_valid  = in_valid;
  assign i0.op_a      = op_a;
  assign i0.op_b      = op_b;
  assign i0.sum       = sum;
  assign i0.cout      = cout;
  assign i0.out_ready = out_ready;
  assign i1.in_valid  = in_valid;
  assign i1.op_a      = op_a;
  assign i1.op_b      = op_b;
  assign i1.sum       = sum;
  assign i1.cout      = cout;
  assign i1.out_ready = out_ready;

  add_result_queue #(.WIDTH(32), .DEPTH(4), .SATURATE(1'b0)) dut0 (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (i0.slave),
    .clr_stats  (clr_stats),
    .ovf_count  (ovf_count0),
    .ovf_sticky (ovf_sticky0)
  );

  add_result_queue #(.WIDTH(32), .DEPTH(4), .SATURATE(1'b1)) dut1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (i1.slave),
    .clr_stats  (clr_stats),
    .ovf_count  (ovf_count1),
    .ovf_sticky (ovf_sticky1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] s, input logic c);
    op_a = a;
    op_b = b;
    sum  = s;
    cout = c;
  endtask

  task automatic push1(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] s, input logic c);
    drive(a, b, s, c);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic pop1;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired vecs=%0d", vecs);
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; clr_stats = 1'b0;
    drive('0, '0, '0, 1'b0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // reset state
    chk("rst_in_ready",  i0.in_ready,  1);
    chk("rst_out_valid", i0.out_valid, 0);
    chk("rst_out_sum",   i0.out_sum,   0);
    chk("rst_out_ovf",   i0.out_ovf,   0);
    chk("rst_out_neg",   i0.out_neg,   0);
    chk("rst_out_zero",  i0.out_zero,  0);
    chk("rst_out_carry", i0.out_carry, 0);
    chk("rst_ovf_count", ovf_count0,   0);
    chk("rst_sticky",    ovf_sticky0,  0);
    chk("rst_sat_sum",   i1.out_sum,   0);

    // negative overflow
    push1(32'h8000_0001, 32'h8000_0001, 32'h0000_0002, 1'b1);
    chk("nov_valid",    i0.out_valid, 1);
    chk("nov_sum0",     i0.out_sum,   32'h0000_0002);
    chk("nov_ovf0",     i0.out_ovf,   1);
    chk("nov_carry0",   i0.out_carry, 1);
    chk("nov_neg0",     i0.out_neg,   0);
    chk("nov_sum1",     i1.out_sum,   32'h8000_0000);
    chk("nov_neg1",     i1.out_neg,   1);
    chk("nov_carry1",   i1.out_carry, 1);
    chk("nov_cnt0",     ovf_count0,   1);
    chk("nov_cnt1",     ovf_count1,   1);
    chk("nov_sticky0",  ovf_sticky0,  1);
    chk("nov_sticky1",  ovf_sticky1,  1);
    pop1();
    chk("nov_popped",   i0.out_valid, 0);

    // positive overflow
    push1(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'hFFFF_FFFE, 1'b0);
    chk("pov_sum0",  i0.out_sum,   32'hFFFF_FFFE);
    chk("pov_ovf0",  i0.out_ovf,   1);
    chk("pov_neg0",  i0.out_neg,   1);
    chk("pov_sum1",  i1.out_sum,   32'h7FFF_FFFF);
    chk("pov_neg1",  i1.out_neg,   0);
    chk("pov_ovf1",  i1.out_ovf,   1);
    chk("pov_cnt0",  ovf_count0,   2);
    pop1();

    // mixed signs, no overflow; then 0 + 0
    push1(32'h70FF_9FFC, 32'hF2FD_9FFC, 32'h63FD_3FF8, 1'b1);
    chk("mix_sum1",  i1.out_sum,   32'h63FD_3FF8);
    chk("mix_ovf",   i0.out_ovf,   0);
    chk("mix_carry", i0.out_carry, 1);
    chk("mix_zero",  i0.out_zero,  0);
    chk("mix_neg",   i0.out_neg,   0);
    chk("mix_cnt",   ovf_count0,   2);
    pop1();
    push1('0, '0, '0, 1'b0);
    chk("zero_zero", i0.out_zero,  1);
    chk("zero_ovf",  i0.out_ovf,   0);
    chk("zero_sum",  i0.out_sum,   0);
    pop1();

    // fill under backpressure, fifth push held
    for (int t = 1; t <= 4; t++) begin
      chk("full_ready_pre", i0.in_ready, 1);
      push1(32'(t), '0, 32'(t), 1'b0);
    end
    chk("full_ready_low", i0.in_ready, 0);
    drive(32'd5, '0, 32'd5, 1'b0);
    in_valid = 1'b1;
    tick();
    chk("full_held",      i0.in_ready, 0);
    chk("full_head1",     i0.out_sum,  1);
    out_ready = 1'b1;
    tick();
    chk("full_head2",     i0.out_sum,  2);
    chk("full_reready",   i0.in_ready, 1);
    tick();
    in_valid = 1'b0;
    for (int t = 3; t <= 5; t++) begin
      chk("full_order", i0.out_sum, 32'(t));
      tick();
    end
    out_ready = 1'b0;
    chk("full_drained", i0.out_valid, 0);

    // three complete passes around the pointers
    for (int p = 0; p < 3; p++) begin
      for (int t = 0; t < 4; t++)
        push1(32'(16 * p + t), '0, 32'(16 * p + t), 1'b0);
      chk("wrap_full", i0.in_ready, 0);
      for (int t = 0; t < 4; t++) begin
        chk("wrap_order", i0.out_sum, 32'(16 * p + t));
        pop1();
      end
      chk("wrap_empty", i0.out_valid, 0);
    end

    // simultaneous push and pop at count 2
    push1(32'h11, '0, 32'h11, 1'b0);
    push1(32'h22, '0, 32'h22, 1'b0);
    drive(32'h33, '0, 32'h33, 1'b0);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick();
    in_valid  = 1'b0;
    chk("pp_head", i0.out_sum, 32'h22);
    tick();
    chk("pp_next", i0.out_sum, 32'h33);
    chk("pp_live", i0.out_valid, 1);
    tick();
    out_ready = 1'b0;
    chk("pp_empty", i0.out_valid, 0);

    // clear wins over a same-cycle overflow push
    clr_stats = 1'b1;
    push1(32'h8000_0001, 32'h8000_0001, 32'h0000_0002, 1'b1);
    clr_stats = 1'b0;
    chk("clr_cnt",    ovf_count0,  0);
    chk("clr_sticky", ovf_sticky0, 0);
    chk("clr_ovf",    i0.out_ovf,  1);
    pop1();

    // asynchronous reset with three entries queued
    push1(32'h1, '0, 32'h1, 1'b0);
    push1(32'h8000_0001, 32'h8000_0001, 32'h0000_0002, 1'b1);
    push1(32'h3, '0, 32'h3, 1'b0);
    chk("ar_pre_cnt", ovf_count0, 1);
    rst_n = 1'b0;
    #1;
    chk("ar_valid",  i0.out_valid, 0);
    chk("ar_ready",  i0.in_ready,  1);
    chk("ar_cnt",    ovf_count0,   0);
    chk("ar_sticky", ovf_sticky0,  0);
    #1;
    rst_n = 1'b1;
    push1(32'h55, '0, 32'h55, 1'b0);
    chk("ar_head",  i0.out_sum,   32'h55);
    pop1();
    chk("ar_alone", i0.out_valid, 0);

    // sustained overflow stream saturates the counter
    drive(32'h8000_0001, 32'h8000_0001, 32'h0000_0002, 1'b1);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    repeat (65534) tick();
    chk("sat_fffe",  ovf_count0,  16'hFFFE);
    chk("thr_ready", i0.in_ready, 1);
    repeat (3) tick();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    tick();
    chk("sat_ffff0", ovf_count0,  16'hFFFF);
    chk("sat_ffff1", ovf_count1,  16'hFFFF);
    chk("sat_stick", ovf_sticky0, 1);
    clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0;
    chk("clr_plain", ovf_count0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/add_result_queue.md
# add_result_queue

Downstream stage of the 32-bit ripple-carry adder. Each cycle it can accept one add result (operands, sum, carry-out) under a valid/ready handshake. For every accepted result it derives the signed status flags and can optionally saturate the sum on signed overflow. Results are buffered in a small FIFO for the consumer, and a running overflow statistic is kept for debug and verification.

## Interface
Parameters:
- WIDTH, 32, operand/sum width in bits
- DEPTH, 4, FIFO entries (power of two, ≥2)
- SATURATE, 0, 1 = replace overflowed sums with signed max/min

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  producer has a result
- in_ready  out  1  block can accept
- op_a  in  WIDTH  first operand fed to adder
- op_b  in  WIDTH  second operand fed to adder
- sum  in  WIDTH  adder sum
- cout  in  1  adder carry-out
- out_valid  out  1  head entry available
- out_ready  in  1  consumer takes head entry
- out_sum  out  WIDTH  result (saturated if SATURATE=1 and overflow)
- out_ovf  out  1  signed overflow
- out_neg  out  1  MSB of out_sum
- out_zero  out  1  out_sum == 0
- out_carry  out  1  raw cout
- ovf_count  out  16  accepted overflow events, saturating
- ovf_sticky  out  1  set on any accepted overflow
- clr_stats  in  1  synchronous clear of ovf_count/ovf_sticky

## Operation
- Push occurs when in_valid && in_ready. Pop occurs when out_valid && out_ready.
- in_ready = (count < DEPTH). It depends only on registered state, with no combinational path from out_ready.
- out_valid = (count != 0). Head fields come straight from storage registers.
- Flags are computed at push on the incoming values and stored with the entry:
  - ovf = (op_a[MSB] == op_b[MSB]) && (sum[MSB] != op_a[MSB])
  - If SATURATE && ovf, the stored sum is op_a[MSB] ? {1,0…0} : {0,1…1}. Otherwise the stored sum is the input sum unmodified.
  - neg and zero are evaluated on the stored sum.
  - carry = cout, regardless of saturation.
- FIFO uses circular read/write pointers of log2(DEPTH) bits, wrapping DEPTH-1 → 0, plus a count register of log2(DEPTH)+1 bits.
- Simultaneous push and pop with 0 < count < DEPTH: both pointers advance and count is unchanged.
- Push and pop cannot coincide at full, because in_ready is low. Pop cannot occur at empty.
- Stats update:
  - clr_stats has priority: when high, ovf_count ← 0 and ovf_sticky ← 0, even if an overflow push happens in the same cycle.
  - Otherwise a push with ovf=1 sets ovf_sticky and increments ovf_count, holding at 16'hFFFF.
- Reset may assert at any time. FIFO contents are discarded and all pointers, count and stats are cleared. In-flight data is lost without error indication.

## Timing
- Reset values: in_ready=1, out_valid=0, out_sum=0, out_ovf=0, out_neg=0, out_zero=0, out_carry=0, ovf_count=0, ovf_sticky=0.
- Storage is cleared on reset, so empty-FIFO outputs read 0.
- Latency: a result pushed at edge k has out_valid=1 during cycle k+1 when the FIFO was empty. Output data is stable until the edge at which it is popped.
- in_ready deasserts the cycle after the push that fills the FIFO. It reasserts the cycle after the first pop from full.
- Stats reflect a push one cycle after its edge.
- Throughput: one result per cycle sustained when out_ready is held high.

## Test plan
- Negative overflow: push a=0x80000001, b=0x80000001, sum=0x00000002, cout=1.
  - SATURATE=0 → out_sum=0x00000002, ovf=1, carry=1, neg=0.
  - SATURATE=1 → out_sum=0x80000000, neg=1.
  - In both cases ovf_count=1 and ovf_sticky=1.
- Positive overflow: push a=b=0x7FFFFFFF, sum=0xFFFFFFFE, cout=0.
  - SATURATE=0 → ovf=1, neg=1.
  - SATURATE=1 → out_sum=0x7FFFFFFF, neg=0.
- Mixed signs, no overflow: push a=0x70FF9FFC, b=0xF2FD9FFC, sum=0x63FD3FF8, cout=1 → ovf=0, carry=1, zero=0, neg=0. Also push 0+0 → zero=1.
- Full/backpressure: hold out_ready=0 and push 5 results tagged 1..5.
  - in_ready goes low after the 4th push; the 5th is held.
  - Raise out_ready → pops return 1..4 in order, then 5 after its push.
  - Pointers wrap correctly over 3 full passes.
- Simultaneous push/pop and stats:
  - With count=2, push and pop in the same cycle → count remains 2 and order is preserved.
  - Assert clr_stats in the same cycle as an overflow push → ovf_count=0, ovf_sticky=0.
  - Push 65537 overflows → ovf_count=0xFFFF.
- Reset mid-operation: with 3 entries queued, pulse rst_n low between edges → immediately out_valid=0, in_ready=1, stats=0. After release, the next push appears alone at the head.
